// File: rtl/prism_cfg_sequencer.sv
// rtl/prism_cfg_sequencer.sv - PRISM configuration load sequencer
// Queues (addr, data) words, then halts PRISM, streams them into its debug port and re-enables it.
module prism_cfg_sequencer #(
   parameter int DEPTH        = 4,
   parameter int RESET_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    push_valid,
   output logic                    push_ready,
   input  logic [5:0]              push_addr,
   input  logic [31:0]             push_data,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    auto_enable,
   input  logic                    irq_clear,
   output logic                    debug_reset,
   output logic                    fsm_enable,
   output logic                    debug_wr,
   output logic [5:0]              debug_addr,
   output logic [31:0]             debug_wdata,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    done_irq
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RST  = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;

   logic [1:0]    state;
   logic [3:0]    rst_cnt;
   logic          en_latch;

   logic [37:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level;
   logic [37:0]   head;
   logic          full;
   logic          push_fire;
   logic          pop_fire;

   assign full       = (level == (AW+1)'(DEPTH));
   assign push_ready = !full;
   // abort discards a same-cycle push as well as the queued entries
   assign push_fire  = push_valid && push_ready && !abort;
   assign pop_fire   = (state == S_WR) && !abort;

   assign head        = mem[rd_ptr];
   assign debug_addr  = head[37:32];
   assign debug_wdata = head[31:0];
   assign debug_wr    = (state == S_WR);
   assign debug_reset = (state == S_RST) || (state == S_WR);
   assign busy        = (state != S_IDLE);
   assign fifo_level  = level;

   always_ff @(posedge clk) begin
      if (push_fire) begin
         mem[wr_ptr] <= {push_addr, push_data};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_fire) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push_fire && !pop_fire) begin
            level <= level + (AW+1)'(1);
         end else if (pop_fire && !push_fire) begin
            level <= level - (AW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rst_cnt    <= '0;
         en_latch   <= 1'b0;
         fsm_enable <= 1'b0;
      end else if (abort) begin
         state      <= S_IDLE;
         fsm_enable <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_RST;
                  rst_cnt    <= 4'(RESET_CYCLES - 1);
                  en_latch   <= auto_enable;
                  fsm_enable <= 1'b0;
               end
            end
            S_RST: begin
               if (rst_cnt == 4'd0) begin
                  state <= (level != '0) ? S_WR : S_FIN;
               end else begin
                  rst_cnt <= rst_cnt - 4'd1;
               end
            end
            S_WR: begin
               // a push landing on the last pop keeps the stream going
               if (level == (AW+1)'(1) && !push_fire) begin
                  state <= S_FIN;
               end
            end
            default: begin
               state      <= S_IDLE;
               fsm_enable <= en_latch;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_irq <= 1'b0;
      end else if (state == S_FIN && !abort) begin
         done_irq <= 1'b1;
      end else if (irq_clear) begin
         done_irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// tb/tb_prism_cfg_sequencer.sv - self-checking bench for prism_cfg_sequencer
// Scenario tasks compare the DUT against a queue-based model of the load sequence.
module tb_prism_cfg_sequencer;

   localparam int DEPTH = 4;
   localparam int R     = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          push_valid;
   logic          push_ready;
   logic [5:0]    push_addr;
   logic [31:0]   push_data;
   logic          start;
   logic          abort;
   logic          auto_enable;
   logic          irq_clear;
   logic          debug_reset;
   logic          fsm_enable;
   logic          debug_wr;
   logic [5:0]    debug_addr;
   logic [31:0]   debug_wdata;
   logic          busy;
   logic [LW-1:0] fifo_level;
   logic          done_irq;

   int checks   = 0;
   int failures = 0;

   logic [37:0] model_q[$];

   prism_cfg_sequencer #(.DEPTH(DEPTH), .RESET_CYCLES(R)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_addr   (push_addr),
      .push_data   (push_data),
      .start       (start),
      .abort       (abort),
      .auto_enable (auto_enable),
      .irq_clear   (irq_clear),
      .debug_reset (debug_reset),
      .fsm_enable  (fsm_enable),
      .debug_wr    (debug_wr),
      .debug_addr  (debug_addr),
      .debug_wdata (debug_wdata),
      .busy        (busy),
      .fifo_level  (fifo_level),
      .done_irq    (done_irq)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_entry(input logic [5:0] a, input logic [31:0] d);
      push_valid = 1'b1;
      push_addr  = a;
      push_data  = d;
      tick();
      push_valid = 1'b0;
      if (model_q.size() < DEPTH) model_q.push_back({a, d});
   endtask

   task automatic clear_irq();
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      push_valid = 0; push_addr = 0; push_data = 0; start = 0;
      abort = 0; auto_enable = 0; irq_clear = 0;
      #12;
      checks++;
      if ({push_ready, debug_reset, fsm_enable, debug_wr, busy, done_irq} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 100000",
                  {push_ready, debug_reset, fsm_enable, debug_wr, busy, done_irq});
      end
      checks++;
      if (fifo_level !== '0) begin
         failures++;
         $display("FAIL reset_level: got %0d expected 0", fifo_level);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (fifo_level !== '0 || push_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset: level %0d ready %b expected 0 1", fifo_level, push_ready);
      end
   endtask

   task automatic test_normal_load();
      logic [5:0]  ea[3];
      logic [31:0] ed[3];
      ea[0] = 6'h04; ea[1] = 6'h08; ea[2] = 6'h0C;
      ed[0] = 32'h11111111; ed[1] = 32'h22222222; ed[2] = 32'h33333333;
      for (int i = 0; i < 3; i++) push_entry(ea[i], ed[i]);
      checks++;
      if (fifo_level !== LW'(3)) begin
         failures++;
         $display("FAIL normal_level: got %0d expected 3", fifo_level);
      end
      start = 1'b1; auto_enable = 1'b1;
      tick();
      start = 1'b0; auto_enable = 1'b0;
      model_q.delete();
      for (int k = 1; k <= 7; k++) begin
         checks++;
         if (debug_reset !== (k <= 5) || debug_wr !== (k >= 3 && k <= 5)) begin
            failures++;
            $display("FAIL normal_ctrl cycle %0d: rst %b wr %b expected %b %b",
                     k, debug_reset, debug_wr, (k <= 5), (k >= 3 && k <= 5));
         end
         if (k >= 3 && k <= 5) begin
            checks++;
            if (debug_addr !== ea[k-3] || debug_wdata !== ed[k-3]) begin
               failures++;
               $display("FAIL normal_data cycle %0d: got %h/%h expected %h/%h",
                        k, debug_addr, debug_wdata, ea[k-3], ed[k-3]);
            end
         end
         if (k == 7) begin
            checks++;
            if (fsm_enable !== 1'b1 || done_irq !== 1'b1 || busy !== 1'b0) begin
               failures++;
               $display("FAIL normal_done: en %b irq %b busy %b expected 1 1 0",
                        fsm_enable, done_irq, busy);
            end
         end
         tick();
      end
   endtask

   task automatic test_full_fifo();
      int wr_count;
      logic [37:0] e;
      clear_irq();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (push_ready !== (model_q.size() < DEPTH)) begin
            failures++;
            $display("FAIL full_ready push %0d: got %b expected %b",
                     i, push_ready, (model_q.size() < DEPTH));
         end
         push_entry(6'(8 + i), 32'hA000_0000 + 32'(i));
      end
      checks++;
      if (fifo_level !== LW'(DEPTH)) begin
         failures++;
         $display("FAIL full_level: got %0d expected %0d", fifo_level, DEPTH);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      wr_count = 0;
      for (int k = 1; k <= 10; k++) begin
         if (debug_wr === 1'b1) begin
            wr_count++;
            e = (model_q.size() != 0) ? model_q.pop_front() : 38'h0;
            checks++;
            if ({debug_addr, debug_wdata} !== e) begin
               failures++;
               $display("FAIL full_data cycle %0d: got %h expected %h",
                        k, {debug_addr, debug_wdata}, e);
            end
         end
         tick();
      end
      checks++;
      if (wr_count != DEPTH || done_irq !== 1'b1) begin
         failures++;
         $display("FAIL full_writes: got %0d irq %b expected %0d 1", wr_count, done_irq, DEPTH);
      end
      model_q.delete();
   endtask

   task automatic test_empty_start();
      clear_irq();
      start = 1'b1; auto_enable = 1'b0;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         checks++;
         if (debug_reset !== (k <= 2) || debug_wr !== 1'b0 || fsm_enable !== 1'b0) begin
            failures++;
            $display("FAIL empty_ctrl cycle %0d: rst %b wr %b en %b expected %b 0 0",
                     k, debug_reset, debug_wr, fsm_enable, (k <= 2));
         end
         checks++;
         if (done_irq !== (k == 4)) begin
            failures++;
            $display("FAIL empty_irq cycle %0d: got %b expected %b", k, done_irq, (k == 4));
         end
         tick();
      end
   endtask

   task automatic test_abort();
      clear_irq();
      for (int i = 0; i < 3; i++) push_entry(6'(i + 1), $urandom);
      start = 1'b1; auto_enable = 1'b1;
      tick();
      start = 1'b0; auto_enable = 1'b0;
      tick();
      tick();
      checks++;
      if (debug_wr !== 1'b1 || {debug_addr, debug_wdata} !== model_q[0]) begin
         failures++;
         $display("FAIL abort_first_write: wr %b data %h expected 1 %h",
                  debug_wr, {debug_addr, debug_wdata}, model_q[0]);
      end
      abort = 1'b1;
      push_valid = 1'b1; push_addr = 6'h3F; push_data = 32'hDEADBEEF;
      tick();
      abort = 1'b0; push_valid = 1'b0;
      model_q.delete();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (debug_wr !== 1'b0 || debug_reset !== 1'b0 || busy !== 1'b0 ||
             fifo_level !== '0 || fsm_enable !== 1'b0 || done_irq !== 1'b0) begin
            failures++;
            $display("FAIL abort_state cycle %0d: wr %b rst %b busy %b lvl %0d en %b irq %b expected all 0",
                     k, debug_wr, debug_reset, busy, fifo_level, fsm_enable, done_irq);
         end
         tick();
      end
   endtask

   task automatic test_irq_clear();
      clear_irq();
      push_entry(6'h10, 32'h5555AAAA);
      model_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k < 4; k++) tick();
      checks++;
      if (busy !== 1'b1 || debug_reset !== 1'b0 || done_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_fin: busy %b rst %b irq %b expected 1 0 0", busy, debug_reset, done_irq);
      end
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      checks++;
      if (done_irq !== 1'b1) begin
         failures++;
         $display("FAIL irq_same_cycle: got %b expected 1", done_irq);
      end
      irq_clear = 1'b1;
      tick();
      irq_clear = 1'b0;
      checks++;
      if (done_irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_later: got %b expected 0", done_irq);
      end
   endtask

   task automatic test_start_busy();
      int wr_count;
      int done_rises;
      clear_irq();
      push_entry(6'h21, 32'h0BAD_F00D);
      push_entry(6'h22, 32'h0000_CAFE);
      model_q.delete();
      start = 1'b1; auto_enable = 1'b1;
      tick();
      start = 1'b0; auto_enable = 1'b0;
      wr_count = 0;
      done_rises = 0;
      for (int k = 1; k <= 12; k++) begin
         if (debug_wr === 1'b1) wr_count++;
         if (k == 6) begin
            checks++;
            if (done_irq !== 1'b1 || fsm_enable !== 1'b1 || busy !== 1'b0) begin
               failures++;
               $display("FAIL busy_done: irq %b en %b busy %b expected 1 1 0", done_irq, fsm_enable, busy);
            end
         end
         if (k > 6 && (busy !== 1'b0 || debug_reset !== 1'b0)) done_rises++;
         start = (k == 2 || k == 4);
         tick();
      end
      start = 1'b0;
      checks++;
      if (wr_count != 2 || done_rises != 0) begin
         failures++;
         $display("FAIL busy_restart: writes %0d extra_busy %0d expected 2 0", wr_count, done_rises);
      end
   endtask

   task automatic test_random_loads();
      int np;
      int n;
      logic ae;
      logic [37:0] e;
      for (int it = 0; it < 20; it++) begin
         clear_irq();
         np = $urandom_range(0, 6);
         for (int i = 0; i < np; i++) push_entry(6'($urandom), $urandom);
         checks++;
         if (fifo_level !== LW'(model_q.size())) begin
            failures++;
            $display("FAIL rand_level iter %0d: got %0d expected %0d", it, fifo_level, model_q.size());
         end
         n = model_q.size();
         ae = 1'($urandom_range(0, 1));
         start = 1'b1; auto_enable = ae;
         tick();
         start = 1'b0; auto_enable = 1'b0;
         for (int k = 1; k <= R + n + 2; k++) begin
            checks++;
            if (debug_reset !== (k <= R + n) || debug_wr !== (k > R && k <= R + n) ||
                busy !== (k <= R + n + 1)) begin
               failures++;
               $display("FAIL rand_ctrl iter %0d cycle %0d: rst %b wr %b busy %b expected %b %b %b",
                        it, k, debug_reset, debug_wr, busy,
                        (k <= R + n), (k > R && k <= R + n), (k <= R + n + 1));
            end
            if (k > R && k <= R + n) begin
               e = model_q.pop_front();
               checks++;
               if ({debug_addr, debug_wdata} !== e) begin
                  failures++;
                  $display("FAIL rand_data iter %0d cycle %0d: got %h expected %h",
                           it, k, {debug_addr, debug_wdata}, e);
               end
            end
            checks++;
            if (k <= R + n + 1) begin
               if (fsm_enable !== 1'b0 || done_irq !== 1'b0) begin
                  failures++;
                  $display("FAIL rand_pending iter %0d cycle %0d: en %b irq %b expected 0 0",
                           it, k, fsm_enable, done_irq);
               end
            end else if (fsm_enable !== ae || done_irq !== 1'b1) begin
               failures++;
               $display("FAIL rand_done iter %0d: en %b irq %b expected %b 1", it, fsm_enable, done_irq, ae);
            end
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal_load();
      test_full_fifo();
      test_empty_start();
      test_abort();
      test_irq_clear();
      test_start_busy();
      test_random_loads();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
